terminal_feeder: RTL
====================

# terminal_feeder

Upstream byte-stream producer for the text terminal overlay. It accepts host characters through a small FIFO, interprets a minimal set of control codes, tracks a shadow cursor, and emits the sequential `screen_byte` / `screen_clk` write stream consumed by `terminalscreen`. Newline, clear and wrap are expanded here into the literal byte sequences the terminal understands, namely space padding and the 0x00 home code. The downstream block stays a dumb sequential writer.

## Interface
- `TCOLS`, default 64: characters per row.
- `TROWS`, default 40: rows per screen.
- `FIFO_DEPTH`, default 16: input FIFO entries, power of two.
- `clk`, in, 1: single block clock.
- `reset`, in, 1: asynchronous, active-high.
- `wr_en`, in, 1: host write strobe; accepted when `!full`.
- `wr_data`, in, 8: host character.
- `full`, out, 1: FIFO full; writes while full are dropped.
- `busy`, out, 1: FIFO non-empty or a sequence in progress.
- `cursor`, out, 12: shadow write position, 0 to `TCOLS*TROWS`.
- `screen_clk`, out, 1: write strobe to `terminalscreen`.
- `screen_byte`, out, 8: byte to `terminalscreen`; stable for the whole strobe cycle.

## Operation
- `SCREEN_SIZE = TCOLS*TROWS` (2560 at defaults).
- **Byte emission:** three phases per byte, always in this order.
  - SETUP: `screen_byte` is driven, `screen_clk` is 0.
  - HIGH: `screen_clk` is 1.
  - HOLD: `screen_clk` is 0 and the byte is unchanged.
  - This guarantees setup before the rising edge and hold through the falling edge.
- **Reset:** outputs go to `screen_clk`=0, `screen_byte`=0x00, `cursor`=0, `full`=0, `busy`=1, FIFO empty.
  - The first action after reset is emitting 0x00 to home the terminal.
- **Character handling**, per popped FIFO byte:
  - 0x20–0x7F:
    - If `cursor==SCREEN_SIZE`, first emit 0x00 and set `cursor`=0 (wrap to top).
    - Then emit the byte and increment `cursor`.
  - 0x0A (newline): emit `TCOLS - cursor%TCOLS` spaces (0x20), incrementing `cursor` per byte.
    - At column 0 this emits a full blank row.
    - The wrap rule above is applied before each space.
  - 0x0C (clear): emit 0x00, then `SCREEN_SIZE` spaces, then 0x00; `cursor`=0 at the end.
  - 0x00 (home): emit 0x00 and set `cursor`=0.
  - 0x80–0xFF and all other codes below 0x20: dropped with no emission, taking one cycle.
- **FSM states:**
  - IDLE: go to FETCH if the FIFO is non-empty.
  - FETCH: pop one byte, decode it, load the repeat counter and prefix/suffix flags.
  - SETUP → HIGH → HOLD: emit one byte.
  - After HOLD:
    - If the repeat counter is >0 or a prefix/suffix is pending, return to SETUP.
    - Otherwise go to IDLE.
- **Repeat counter:** 12 bits; the clear sequence count is 2562 total bytes.
- **FIFO:** a simultaneous write and pop when full is allowed; the write is accepted.

## Timing
- A write at cycle N into an empty FIFO with the FSM in IDLE:
  - FETCH at N+1.
  - SETUP at N+2.
  - `screen_clk` high at N+3.
  - `cursor` updated at N+4, in HOLD.
- Steady state: 3 cycles per emitted byte.
  - Newline: 1 + 3·pad cycles.
  - Clear: 1 + 3·2562 = 7687 cycles.
- `full` and `busy` are registered, reflecting state after the current edge.
- **Reset mid-sequence:**
  - Sequence aborted, FIFO flushed.
  - `screen_clk` drops immediately (asynchronous).
  - The home 0x00 is re-emitted.

## Structure
- Package `terminal_pkg`:
  - `TCOLS`, `TROWS`, `SCREEN_SIZE`.
  - Control code constants `CH_HOME`=0x00, `CH_NL`=0x0A, `CH_CLR`=0x0C, `CH_SPACE`=0x20.
  - FSM state enum.
- Sub-module `byte_fifo`: synchronous FIFO with parameterised depth and width, exposing `full`/`empty`.
- The FSM and cursor logic live in `terminal_feeder` itself.

## Test plan
- **Reset then idle:** exactly one strobe with byte 0x00 is emitted, then `busy`=0 and `cursor`=0.
- **Write "AB":** strobes carry 0x41 then 0x42, spaced 3 cycles apart; first `screen_clk` high at N+3; `cursor`=2.
- **Write "HELLO" then 0x0A:** 5 chars, then 59 spaces; `cursor`=64.
- **Write 0x0C at cursor 100:** emits 0x00, 2560×0x20, 0x00 (2562 strobes); `cursor`=0.
- **Write 17 bytes back-to-back while busy:** `full` asserts at 16 and the 17th is dropped.
- **Write 2561 printable chars:** the 2561st is preceded by 0x00 and lands with `cursor`=1.
- **Assert `reset` during a clear:** `screen_clk`=0 immediately, FIFO empty, one 0x00 emitted after release.

Source files
------------

// File: rtl/terminal_pkg.sv
// ----------------------------------------------------------------------------
// terminal_pkg
// Shared definitions for the terminal byte-stream feeder:
//   - screen geometry defaults (TCOLS, TROWS, SCREEN_SIZE)
//   - repeat counter / cursor width
//   - control code constants understood by the feeder and terminalscreen
//   - feeder FSM state encoding
//   - small decode helpers
// ----------------------------------------------------------------------------
package terminal_pkg;

    localparam int TCOLS       = 64;
    localparam int TROWS       = 40;
    localparam int SCREEN_SIZE = TCOLS * TROWS;

    // Cursor and repeat counter share this width; 12 bits holds SCREEN_SIZE.
    localparam int CNT_W = 12;

    localparam logic [7:0] CH_HOME       = 8'h00;
    localparam logic [7:0] CH_NL         = 8'h0A;
    localparam logic [7:0] CH_CLR        = 8'h0C;
    localparam logic [7:0] CH_SPACE      = 8'h20;
    localparam logic [7:0] CH_LAST_PRINT = 8'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_HIGH,
        ST_HOLD
    } feeder_state_t;

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= CH_SPACE) && (ch <= CH_LAST_PRINT);
    endfunction

    // The next emitted byte is a home code while the prefix is pending, or
    // once the body run is exhausted (only the suffix can remain then).
    function automatic logic starts_with_home(input logic             prefix,
                                              input logic [CNT_W-1:0] count);
        return prefix || (count == '0);
    endfunction

endpackage

// File: rtl/terminal_feeder_byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
// Synchronous show-ahead FIFO. The head entry is visible on data_o whenever
// empty_o is low; pop_i consumes it at the next edge.
// Ports:
//   clk, reset        block clock, asynchronous active-high reset
//   push_i, data_i    write strobe and data (dropped while full unless a pop
//                     happens in the same cycle)
//   pop_i             consume the head entry
//   data_o            head entry
//   full_o, empty_o   occupancy flags, derived from registered count
// ----------------------------------------------------------------------------
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rptr_q];

    // A pop in the same cycle frees a slot, so a write while full still lands.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/terminal_feeder.sv
// ----------------------------------------------------------------------------
// terminal_feeder
// Turns host characters into the sequential write stream for terminalscreen.
// Control codes are expanded here (newline -> space padding, clear -> home +
// full screen of spaces + home, wrap -> home) so the screen stays a dumb
// sequential writer. Every byte goes out as SETUP / HIGH / HOLD.
// Ports:
//   clk, reset              block clock, asynchronous active-high reset
//   wr_en, wr_data          host character write (dropped while full)
//   full                    input FIFO full
//   busy                    FIFO non-empty or a byte sequence in progress
//   cursor                  shadow write position, 0..TCOLS*TROWS
//   screen_clk, screen_byte write strobe and byte towards terminalscreen
// ----------------------------------------------------------------------------
module terminal_feeder #(
    parameter int TCOLS      = terminal_pkg::TCOLS,
    parameter int TROWS      = terminal_pkg::TROWS,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        busy,
    output logic [11:0] cursor,
    output logic        screen_clk,
    output logic [7:0]  screen_byte
);

    import terminal_pkg::*;

    localparam logic [CNT_W-1:0] TCOLS_C       = CNT_W'(TCOLS);
    localparam logic [CNT_W-1:0] SCREEN_SIZE_C = CNT_W'(TCOLS * TROWS);

    feeder_state_t    state_q;
    logic             prefix_q;
    logic             suffix_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       body_q;
    logic             home_q;
    logic [7:0]       byte_q;
    logic             strobe_q;
    logic [CNT_W-1:0] cursor_q;
    logic [CNT_W-1:0] col_q;

    logic [7:0]       fifo_data;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic             seq_more;

    logic             dec_prefix;
    logic             dec_suffix;
    logic             dec_drop;
    logic [CNT_W-1:0] dec_count;
    logic [7:0]       dec_body;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_en),
        .data_i  (wr_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign seq_more = prefix_q || suffix_q || (cnt_q != '0);

    // HOLD of the last byte doubles as the fetch slot for the next character,
    // which keeps back-to-back characters at one byte every three cycles.
    assign fifo_pop = (state_q == ST_FETCH) ||
                      ((state_q == ST_HOLD) && !seq_more && !fifo_empty);

    assign full        = fifo_full;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign cursor      = cursor_q;
    assign screen_clk  = strobe_q;
    assign screen_byte = byte_q;

    // Every character becomes: optional home prefix, a run of body bytes that
    // each advance the cursor, optional home suffix. A full screen only needs
    // a wrap home before the first body byte, since a newline pad always ends
    // on a row boundary.
    always_comb begin
        dec_prefix = 1'b0;
        dec_suffix = 1'b0;
        dec_drop   = 1'b0;
        dec_count  = '0;
        dec_body   = CH_SPACE;
        if (is_printable(fifo_data)) begin
            dec_prefix = (cursor_q == SCREEN_SIZE_C);
            dec_count  = CNT_W'(1);
            dec_body   = fifo_data;
        end else if (fifo_data == CH_NL) begin
            dec_prefix = (cursor_q == SCREEN_SIZE_C);
            dec_count  = TCOLS_C - col_q;
        end else if (fifo_data == CH_CLR) begin
            dec_prefix = 1'b1;
            dec_count  = SCREEN_SIZE_C;
            dec_suffix = 1'b1;
        end else if (fifo_data == CH_HOME) begin
            dec_prefix = 1'b1;
        end else begin
            dec_drop   = 1'b1;
        end
    end

    // Reset parks the FSM in SETUP with a home byte loaded, so the terminal
    // is re-homed as the first action after every reset. The cursor moves on
    // the HIGH->HOLD edge; col_q shadows cursor%TCOLS without a divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_SETUP;
            prefix_q <= 1'b0;
            suffix_q <= 1'b0;
            cnt_q    <= '0;
            body_q   <= CH_SPACE;
            home_q   <= 1'b1;
            byte_q   <= CH_HOME;
            strobe_q <= 1'b0;
            cursor_q <= '0;
            col_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_SETUP: begin
                    strobe_q <= 1'b1;
                    state_q  <= ST_HIGH;
                end
                ST_HIGH: begin
                    strobe_q <= 1'b0;
                    state_q  <= ST_HOLD;
                    if (home_q) begin
                        cursor_q <= '0;
                        col_q    <= '0;
                        if (prefix_q) begin
                            prefix_q <= 1'b0;
                        end else begin
                            suffix_q <= 1'b0;
                        end
                    end else begin
                        cursor_q <= cursor_q + CNT_W'(1);
                        col_q    <= (col_q == TCOLS_C - CNT_W'(1)) ? '0 : col_q + CNT_W'(1);
                        cnt_q    <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if ((state_q == ST_HOLD) && seq_more) begin
                        home_q  <= starts_with_home(prefix_q, cnt_q);
                        byte_q  <= starts_with_home(prefix_q, cnt_q) ? CH_HOME : body_q;
                        state_q <= ST_SETUP;
                    end else if (fifo_pop && !dec_drop) begin
                        prefix_q <= dec_prefix;
                        suffix_q <= dec_suffix;
                        cnt_q    <= dec_count;
                        body_q   <= dec_body;
                        home_q   <= starts_with_home(dec_prefix, dec_count);
                        byte_q   <= starts_with_home(dec_prefix, dec_count) ? CH_HOME : dec_body;
                        state_q  <= ST_SETUP;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
